if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_pkg.sv | 22 ++
 rtl/if_fifo.sv | 61 ++++++
 rtl/if_prefetch.sv | 182 ++++++++++++++++++
 tb/tb_if_prefetch.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the if_prefetch instruction-fetch unit.
package if_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic        fault;
   } if_entry_t;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO: power-of-two depth, generic entry type, synchronous flush.
// Push and pop in the same cycle while full is allowed and leaves the count unchanged.
module if_fifo #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = logic [64:0]
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  entry_t                 push_data,
   input  logic                   pop,
   output entry_t                 head,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];
   assign count   = cnt;

   // NOTE: storage is deliberately not reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: single-outstanding Wishbone classic fetch master,
// prefetch FIFO and pipeline output register. Define IF_PREFETCH_ERR_EN to report bus errors.
module if_prefetch
   import if_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iEn,
   input  logic        iStall,
   input  logic        iRedirect,
   input  logic [31:0] iRedirectPC,
   output logic        oWB_CYC,
   output logic        oWB_STB,
   output logic [31:0] oWB_ADR,
   input  logic        iWB_ACK,
   input  logic        iWB_ERR,
   input  logic [31:0] iWB_DAT,
   output logic        oValid,
   output logic [31:0] oPC,
   output logic [31:0] oPC4,
   output logic [31:0] oIR,
   output logic        oFault,
   output logic        oStall
);

`ifdef IF_PREFETCH_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam int            CW        = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] LAST_FREE = CW'(DEPTH - 1);

   fetch_state_t  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   drain_adr_q, drain_adr_d;
   logic          halt_q, halt_d;
   logic          bus_req;
   logic          push;
   if_entry_t     push_entry;
   if_entry_t     head;
   logic          pop;
   logic          fifo_empty;
   logic          fifo_full;
   logic [CW-1:0] fifo_count;
   logic          err;
   logic          term;
   logic          launch_ok;
   logic          room_after_ack;
   logic [31:0]   target;
   logic          fault_q;

   assign target    = word_align(iRedirectPC);
   assign err       = ERR_EN & iWB_ERR & ~iWB_ACK;
   assign term      = iWB_ACK | err;
   assign pop       = ~iRedirect & ~iStall & ~fifo_empty;
   assign launch_ok = iEn & ~iRedirect & ~halt_q & ~fifo_full;
   // After a push the FIFO must still have a slot free before another request may go out.
   assign room_after_ack = pop | (fifo_count < LAST_FREE);

   if_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (if_entry_t)
   ) u_fifo (
      .clk       (iClk),
      .rst       (iRst),
      .flush     (iRedirect),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drain_adr_d = drain_adr_q;
      halt_d      = halt_q;
      bus_req     = 1'b0;
      push        = 1'b0;
      push_entry  = '{pc: pc_q, ir: iWB_DAT, fault: 1'b0};
      case (state_q)
         IDLE: begin
            if (iRedirect) begin
               pc_d    = target;
               halt_d  = 1'b0;
               state_d = iEn ? REQ : IDLE;
            end else if (launch_ok) begin
               state_d = REQ;
            end
         end
         REQ: begin
            bus_req = 1'b1;
            if (iRedirect) begin
               pc_d   = target;
               halt_d = 1'b0;
               if (term) begin
                  state_d = iEn ? REQ : IDLE;
               end else begin
                  drain_adr_d = pc_q;
                  state_d     = DRAIN;
               end
            end else if (iWB_ACK) begin
               push    = 1'b1;
               pc_d    = pc_q + 32'd4;
               state_d = (iEn && !halt_q && room_after_ack) ? REQ : IDLE;
            end else if (err) begin
               push       = 1'b1;
               push_entry = '{pc: pc_q, ir: NOP_INSN, fault: 1'b1};
               halt_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         DRAIN: begin
            bus_req = 1'b1;
            if (iRedirect) begin
               pc_d   = target;
               halt_d = 1'b0;
            end
            if (term) state_d = iEn ? REQ : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q     <= IDLE;
         pc_q        <= word_align(RESET_PC);
         drain_adr_q <= '0;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drain_adr_q <= drain_adr_d;
         halt_q      <= halt_d;
      end
   end

   // Output pipeline register; a redirect squashes it regardless of iStall.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oValid  <= 1'b0;
         oPC     <= RESET_PC;
         oPC4    <= RESET_PC + 32'd4;
         oIR     <= NOP_INSN;
         fault_q <= 1'b0;
      end else if (iRedirect) begin
         oValid  <= 1'b0;
         oIR     <= NOP_INSN;
         fault_q <= 1'b0;
      end else if (!iStall) begin
         if (!fifo_empty) begin
            oValid  <= 1'b1;
            oPC     <= head.pc;
            oPC4    <= head.pc + 32'd4;
            oIR     <= head.ir;
            fault_q <= head.fault;
         end else begin
            oValid  <= 1'b0;
            oIR     <= NOP_INSN;
            fault_q <= 1'b0;
         end
      end
   end

   assign oFault  = ERR_EN & fault_q;
   assign oWB_CYC = bus_req;
   assign oWB_STB = bus_req;
   assign oWB_ADR = (state_q == DRAIN) ? drain_adr_q : pc_q;
   assign oStall  = fifo_empty & ~oValid & ~iRedirect;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed self-checking bench for if_prefetch; a second instance covers a wrapping RESET_PC.
// Honours IF_PREFETCH_ERR_EN for the bus-error scenario.
module tb_if_prefetch;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'hA5A5_A5A5;

   logic        clk;
   logic        rst, en, stall, redirect;
   logic [31:0] redirect_pc;
   logic        wb_cyc, wb_stb, wb_ack, wb_err;
   logic [31:0] wb_adr, wb_dat;
   logic        valid, fault, fetch_stall;
   logic [31:0] pc, pc4, ir;

   logic        rst2;
   logic        wb_cyc2, wb_stb2, wb_ack2;
   logic [31:0] wb_adr2, wb_dat2;
   logic        valid2, fault2, fetch_stall2;
   logic [31:0] pc2, pc4_2, ir2;

   int   errors = 0;
   int   checks = 0;
   int   lat;
   logic err_on;
   int   wait_cnt;
   logic slv_ready, slv_err_hit;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   if_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .iClk(clk), .iRst(rst), .iEn(en), .iStall(stall),
      .iRedirect(redirect), .iRedirectPC(redirect_pc),
      .oWB_CYC(wb_cyc), .oWB_STB(wb_stb), .oWB_ADR(wb_adr),
      .iWB_ACK(wb_ack), .iWB_ERR(wb_err), .iWB_DAT(wb_dat),
      .oValid(valid), .oPC(pc), .oPC4(pc4), .oIR(ir),
      .oFault(fault), .oStall(fetch_stall)
   );

   if_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .iClk(clk), .iRst(rst2), .iEn(1'b1), .iStall(1'b0),
      .iRedirect(1'b0), .iRedirectPC(32'h0),
      .oWB_CYC(wb_cyc2), .oWB_STB(wb_stb2), .oWB_ADR(wb_adr2),
      .iWB_ACK(wb_ack2), .iWB_ERR(1'b0), .iWB_DAT(wb_dat2),
      .oValid(valid2), .oPC(pc2), .oPC4(pc4_2), .oIR(ir2),
      .oFault(fault2), .oStall(fetch_stall2)
   );

   // Slave for the main instance: ACK once the strobe has waited `lat` cycles; ERR instead at addr 8.
   assign slv_ready   = wb_cyc & wb_stb & (wait_cnt >= lat);
   assign slv_err_hit = err_on & (wb_adr == 32'h8);
   assign wb_ack      = slv_ready & ~slv_err_hit;
   assign wb_err      = slv_ready & slv_err_hit;
   assign wb_dat      = wb_adr ^ KEY;

   always @(posedge clk or posedge rst) begin
      if (rst)                           wait_cnt <= 0;
      else if (wb_cyc && !wb_ack && !wb_err) wait_cnt <= wait_cnt + 1;
      else                               wait_cnt <= 0;
   end

   // Zero-wait slave for the wrap instance.
   assign wb_ack2 = wb_cyc2 & wb_stb2;
   assign wb_dat2 = wb_adr2 ^ KEY;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_arrive"}, 32'(valid), 32'd1);
   endtask

   task automatic wait_pc(input string tag, input logic [31:0] target, input int budget);
      int n = 0;
      while (!(valid && pc == target) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_arrive"}, (valid && pc == target) ? pc : 32'hDEAD_BEEF, target);
   endtask

   // Strict back-to-back stream: one new instruction every cycle.
   task automatic check_stream(input string tag, input logic [31:0] start, input int n);
      logic [31:0] e = start;
      for (int i = 0; i < n; i++) begin
         check({tag, "_valid"}, 32'(valid), 32'd1);
         check({tag, "_pc"}, pc, e);
         check({tag, "_pc4"}, pc4, e + 32'd4);
         check({tag, "_ir"}, ir, e ^ KEY);
         e = e + 32'd4;
         @(negedge clk);
      end
   endtask

   // Gaps allowed, but the valid outputs must be consecutive with nothing lost.
   task automatic collect_seq(input string tag, input logic [31:0] start, input int n, input int budget);
      logic [31:0] e = start;
      int got = 0;
      int t = 0;
      while (got < n && t < budget) begin
         if (valid) begin
            check({tag, "_pc"}, pc, e);
            check({tag, "_ir"}, ir, e ^ KEY);
            e = e + 32'd4;
            got++;
         end
         @(negedge clk);
         t++;
      end
      check({tag, "_count"}, 32'(got), 32'(n));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int pushes;
      int hold_bad;
      int n;

      rst = 1'b0; rst2 = 1'b0; en = 1'b0; stall = 1'b0; redirect = 1'b0;
      redirect_pc = '0; lat = 0; err_on = 1'b0;
      #1;
      rst = 1'b1; rst2 = 1'b1;
      @(negedge clk);

      // Reset state
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_pc", pc, 32'h0);
      check("rst_pc4", pc4, 32'h4);
      check("rst_ir", ir, NOP);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_cyc", 32'(wb_cyc), 32'd0);
      check("rst_stb", 32'(wb_stb), 32'd0);

      // Zero-wait stream 0,4,8,...
      en = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      check("first_cyc", 32'(wb_cyc), 32'd1);
      check("first_adr", wb_adr, 32'h0);
      wait_valid("fill", 10);
      check_stream("stream", 32'h0, 6);

      // Stall for 10 cycles: FIFO fills, bus idles, output held at 24
      stall = 1'b1;
      pushes = 0;
      hold_bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (wb_ack) pushes++;
         if (!valid || pc != 32'd24 || ir != (32'd24 ^ KEY)) hold_bad++;
         @(negedge clk);
      end
      check("stall_pushes_le_depth", 32'(pushes <= 4), 32'd1);
      check("stall_bus_idle_full", 32'(wb_cyc), 32'd0);
      check("stall_hold", 32'(hold_bad), 32'd0);
      stall = 1'b0;
      @(negedge clk);
      collect_seq("resume", 32'd28, 8, 40);

      // Redirect in the same cycle as an ACK: response dropped
      redirect = 1'b1;
      redirect_pc = 32'h0000_2000;
      #1;
      check("rd_ack_same_cycle_ack", 32'(wb_ack), 32'd1);
      check("rd_ack_ostall_masked", 32'(fetch_stall), 32'd0);
      @(negedge clk);
      redirect = 1'b0;
      check("rd_ack_valid_next", 32'(valid), 32'd0);
      #1;
      check("rd_ack_ostall", 32'(fetch_stall), 32'd1);
      wait_valid("rd_ack", 10);
      check("rd_ack_pc", pc, 32'h0000_2000);
      check("rd_ack_ir", ir, 32'h0000_2000 ^ KEY);

      // Redirect while a 3-cycle-latency request is pending -> DRAIN
      lat = 3;
      do_reset();
      @(negedge clk);
      check("drain_req_adr", wb_adr, 32'h0);
      @(negedge clk);
      redirect = 1'b1;
      redirect_pc = 32'h0000_1002;
      #1;
      check("drain_no_ack_yet", 32'(wb_ack), 32'd0);
      @(negedge clk);
      redirect = 1'b0;
      check("drain_cyc", 32'(wb_cyc), 32'd1);
      check("drain_stb", 32'(wb_stb), 32'd1);
      check("drain_old_adr", wb_adr, 32'h0);
      wait_valid("drain", 40);
      check("drain_pc", pc, 32'h0000_1000);
      check("drain_pc4", pc4, 32'h0000_1004);
      check("drain_ir", ir, 32'h0000_1000 ^ KEY);

      // Reset in the middle of a bus cycle
      n = 0;
      while (!wb_cyc && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("midrst_cyc_before", 32'(wb_cyc), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_cyc", 32'(wb_cyc), 32'd0);
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_pc", pc, 32'h0);
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_idle", 32'(wb_cyc), 32'd0);

      // Bus error on address 8
      lat = 0;
      err_on = 1'b1;
      en = 1'b1;
      do_reset();
`ifdef IF_PREFETCH_ERR_EN
      wait_pc("err", 32'h8, 20);
      check("err_fault", 32'(fault), 32'd1);
      check("err_ir", ir, NOP);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (wb_cyc) n++;
         @(negedge clk);
      end
      check("err_halt_no_req", 32'(n), 32'd0);
      err_on = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0040;
      @(negedge clk);
      redirect = 1'b0;
      wait_valid("err_resume", 20);
      check("err_resume_pc", pc, 32'h0000_0040);
      check("err_resume_fault", 32'(fault), 32'd0);
`else
      wait_pc("noerr", 32'h4, 20);
      n = 0;
      hold_bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (wb_cyc && wb_adr == 32'h8) n++;
         if (valid && pc == 32'h8) hold_bad++;
         @(negedge clk);
      end
      check("noerr_waits_cycles", 32'(n), 32'd10);
      check("noerr_no_delivery", 32'(hold_bad), 32'd0);
      err_on = 1'b0;
      wait_pc("noerr_resume", 32'h8, 20);
      check("noerr_ir", ir, 32'h8 ^ KEY);
      check("noerr_fault", 32'(fault), 32'd0);
`endif

      // Wrapping RESET_PC on the second instance
      check("wrap_rst_pc", pc2, 32'hFFFF_FFF8);
      check("wrap_rst_pc4", pc4_2, 32'hFFFF_FFFC);
      rst2 = 1'b0;
      n = 0;
      while (!valid2 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("wrap_arrive", 32'(valid2), 32'd1);
      check("wrap_pc0", pc2, 32'hFFFF_FFF8);
      @(negedge clk);
      check("wrap_pc1", pc2, 32'hFFFF_FFFC);
      check("wrap_pc1_pc4", pc4_2, 32'h0000_0000);
      @(negedge clk);
      check("wrap_pc2", pc2, 32'h0000_0000);
      check("wrap_ir2", ir2, 32'h0000_0000 ^ KEY);
      check("wrap_valid2", 32'(valid2), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
